io_port_ctrl: RTL

Buffered, parametrised keyboard/display I/O controller for the 16-bit CPU, the successor to the bare `keyboard`/`display`/`en_inp`/`en_out` wiring. It sits between the CPU's I/O instruction decode (INP, OUT, SKI, SKO, ION, IOF) and the external character devices. It provides an input FIFO fed by a keyboard strobe and an output FIFO drained by a display handshake. It exposes FGI/FGO flags and a level interrupt request gated by an interrupt-enable flip-flop.

---
 rtl/io_pkg.sv | 31 +++
 rtl/io_fifo.sv | 73 +++++++
 rtl/io_port_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared defaults, status-word layout and sizing helpers for the
// keyboard/display I/O controller (io_port_ctrl and io_fifo).
// Optional feature macro used by the controller: IO_OVERRUN_EN.
package io_pkg;

   // Default character width and FIFO depths.
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_IN_DEPTH  = 4;
   localparam int DEF_OUT_DEPTH = 4;

   // Bit positions in the packed {ovr, ien, fgo, fgi} status word that a
   // later status-read instruction will return.
   localparam int ST_FGI = 0;
   localparam int ST_FGO = 1;
   localparam int ST_IEN = 2;
   localparam int ST_OVR = 3;
   localparam int ST_W   = 4;

   typedef struct packed {
      logic ovr;
      logic ien;
      logic fgo;
      logic fgi;
   } io_status_t;

   // Width of an occupancy counter that must represent 0..depth inclusive.
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: show-ahead synchronous FIFO with an explicit occupancy count.
// The head is visible combinationally (0 when empty); a pop takes effect at
// the clock edge. A push into a full FIFO is dropped unless a pop happens in
// the same cycle, and o_drop flags the dropped push. DEPTH must be a power
// of 2 and at least 2 so the pointers wrap naturally.
module io_fifo
   import io_pkg::*;
#(
   parameter int W     = DEF_DATA_W,
   parameter int DEPTH = DEF_IN_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [W-1:0]              i_data,
   output logic [W-1:0]              o_head,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [count_w(DEPTH)-1:0] o_count,
   output logic                      o_drop
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = count_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_count = r_count;

   // A pop on empty is ignored; a push on full survives only alongside a real pop.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_drop    = i_push & ~w_do_push;
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage array write port.
   // NOTE: the data array has no reset; the count gates every read, so stale
   // contents are never visible and the array can map onto plain flops/RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: buffered keyboard/display controller for the 16-bit CPU.
// Input FIFO filled by the keyboard strobe and drained by INP; output FIFO
// filled by OUT and drained by the display valid/ready handshake. Provides
// FGI/FGO, the IEN flip-flop and a level interrupt request.
// Optional feature macro: IO_OVERRUN_EN adds a sticky ovr flag (set by any
// dropped push, cleared by ovr_clr, set wins) that also raises irq.
module io_port_ctrl
   import io_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int IN_DEPTH  = DEF_IN_DEPTH,
   parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
   input  logic                          clkin,
   input  logic                          rst,
   input  logic                          kb_stb,
   input  logic [DATA_W-1:0]             kb_data,
   output logic                          disp_valid,
   output logic [DATA_W-1:0]             disp_data,
   input  logic                          disp_ready,
   input  logic                          cpu_inp_rd,
   output logic [DATA_W-1:0]             cpu_inp_data,
   input  logic                          cpu_out_wr,
   input  logic [DATA_W-1:0]             cpu_out_data,
   input  logic                          ion,
   input  logic                          iof,
   input  logic                          int_ack,
   output logic                          fgi,
   output logic                          fgo,
   output logic                          ien,
   output logic                          irq,
   output logic [count_w(IN_DEPTH)-1:0]  in_count,
   output logic [count_w(OUT_DEPTH)-1:0] out_count
`ifdef IO_OVERRUN_EN
   ,
   output logic                          ovr,
   input  logic                          ovr_clr
`endif
);

   logic w_in_full;
   logic w_in_empty;
   logic w_in_drop;
   logic w_out_full;
   logic w_out_empty;
   logic w_out_drop;
   logic w_disp_pop;
   logic r_ien;

   assign w_disp_pop = disp_valid & disp_ready;

   io_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk     (clkin),
      .rst_n   (rst),
      .i_push  (kb_stb),
      .i_pop   (cpu_inp_rd),
      .i_data  (kb_data),
      .o_head  (cpu_inp_data),
      .o_full  (w_in_full),
      .o_empty (w_in_empty),
      .o_count (in_count),
      .o_drop  (w_in_drop)
   );

   io_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk     (clkin),
      .rst_n   (rst),
      .i_push  (cpu_out_wr),
      .i_pop   (w_disp_pop),
      .i_data  (cpu_out_data),
      .o_head  (disp_data),
      .o_full  (w_out_full),
      .o_empty (w_out_empty),
      .o_count (out_count),
      .o_drop  (w_out_drop)
   );

   assign disp_valid = ~w_out_empty;
   assign fgi        = ~w_in_empty;
   assign fgo        = ~w_out_full;
   assign ien        = r_ien;

   // Interrupt-enable flip-flop: ION sets, IOF or interrupt entry clears, clear wins.
   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         r_ien <= 1'b0;
      end else if (iof | int_ack) begin
         r_ien <= 1'b0;
      end else if (ion) begin
         r_ien <= 1'b1;
      end
   end

`ifdef IO_OVERRUN_EN
   logic r_ovr;
   logic w_unused_in_full;

   assign w_unused_in_full = w_in_full;
   assign ovr              = r_ovr;
   assign irq              = r_ien & (fgi | fgo | r_ovr);

   // Sticky overrun flag: any dropped push sets it; a set beats a same-cycle clear.
   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         r_ovr <= 1'b0;
      end else if (w_in_drop | w_out_drop) begin
         r_ovr <= 1'b1;
      end else if (ovr_clr) begin
         r_ovr <= 1'b0;
      end
   end
`else
   logic w_unused_status;

   // Drops are silent in this build; the full/drop indications have no consumer.
   assign w_unused_status = w_in_full | w_in_drop | w_out_drop;
   assign irq             = r_ien & (fgi | fgo);
`endif

endmodule
